mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address/data width of all address and data buses.
REQ-002 Parameter: TIMEOUT, 15, max cycles a memory access may wait for mem_ready before abort (legal range 1..255).
REQ-003 Port: clk  input  1  single system clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: if_req  input  1  instruction-fetch read request, held until if_gnt.
REQ-006 Port: if_addr  input  ADDR_W  fetch address (current pc).
REQ-007 Port: if_gnt  output  1  one-cycle pulse, fetch request accepted.
REQ-008 Port: if_valid  output  1  one-cycle pulse, if_rdata valid.
REQ-009 Port: if_rdata  output  ADDR_W  fetched instruction word.
REQ-010 Port: ls_req / ls_we  input  1 / 1  load-store request, held until ls_gnt / 1 = write.
REQ-011 Port: ls_addr / ls_wdata  input  ADDR_W / ADDR_W  load-store address / store data.
REQ-012 Port: ls_gnt / ls_valid  output  1 / 1  accept pulse / completion pulse (load data or store ack).
REQ-013 Port: ls_rdata  output  ADDR_W  load data (0 for stores).
REQ-014 Port: mem_en / mem_we  output  1 / 1  shared memory port enable / write.
REQ-015 Port: mem_addr / mem_wdata  output  ADDR_W / ADDR_W  shared port address / write data.
REQ-016 Port: mem_rdata / mem_ready  input  ADDR_W / 1  memory read data / access-complete strobe.
REQ-017 Port: err  output  1  one-cycle pulse, access aborted by timeout.

Function
REQ-018 FSM states SHALL be IDLE, BUSY_IF, BUSY_LS, DONE; one transaction in flight at most.
REQ-019 IDLE: request sampled at edge N -> state BUSY_x and matching gnt high during cycle N+1 only.
REQ-020 On grant, address, we, wdata SHALL be latched; mem_* driven from latches, not from requester inputs.
REQ-021 BUSY_x: mem_en=1 every cycle; mem_we=latched we for BUSY_LS, 0 for BUSY_IF.
REQ-022 mem_ready=1 in BUSY_x -> mem_rdata registered into x_rdata, x_valid pulses next cycle, state DONE.
REQ-023 Minimum latency req->valid = 2 cycles + memory wait cycles (ready in first BUSY cycle gives valid at N+2).
REQ-024 DONE lasts exactly one cycle, mem_en=0, then IDLE; no grant issued in DONE (turnaround cycle).
REQ-025 Timeout counter (8 bit) clears on entering BUSY_x, increments each BUSY cycle without mem_ready.
REQ-026 Counter == TIMEOUT without ready -> abort: x_valid and err pulse together, x_rdata=0, state DONE.
REQ-027 mem_ready in IDLE or DONE SHALL be ignored.
REQ-028 Request dropped before gnt SHALL be withdrawn without side effects.
REQ-029 Simultaneous if_req and ls_req in IDLE: default policy grants ls (data access over fetch).
REQ-030 if_rdata/ls_rdata SHALL hold last value until next completion of same requester.

Reset
REQ-031 reset=1 at a rising edge -> state IDLE, counter 0, all outputs 0 next cycle, including mid-transaction.
REQ-032 Transaction interrupted by reset SHALL produce no valid, no err; mem_en low the cycle after reset edge.
REQ-033 reset has priority over every other event in the same cycle.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: 1-bit last-grant register (reset 0 = if); on conflict grant requester not granted last.
REQ-035 Macro undefined: fixed priority per REQ-029, no last-grant register.
REQ-036 Non-conflicting requests SHALL behave identically in both builds.

Verification
REQ-037 reset 1 cycle, if_req=1 if_addr=0x0, mem_ready=1 immediate, mem_rdata=0xC0000010 -> if_gnt cycle 1, if_valid cycle 2, if_rdata=0xC0000010.
REQ-038 ls_req we=1 addr=0x40 wdata=0xDEADBEEF, ready after 3 cycles -> mem_we=1, mem_addr=0x40 held 3 cycles, ls_valid, ls_rdata=0.
REQ-039 if_req and ls_req together held 4 transactions -> default: ls,ls,... until ls drops; ARB_ROUND_ROBIN_EN: ls,if,ls,if.
REQ-040 mem_ready never asserted, TIMEOUT=15 -> err and if_valid pulse after 15 BUSY cycles, if_rdata=0, IDLE after DONE.
REQ-041 reset asserted in 2nd BUSY_LS cycle -> next cycle mem_en=0, no ls_valid/err, next request granted normally.
REQ-042 mem_ready pulsed in IDLE with no request -> no valid, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port with a per-access timeout.
// Define ARB_ROUND_ROBIN_EN to alternate grants on conflict instead of always favouring load-store.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [ADDR_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic [ADDR_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DONE} state_t;

    // Abort happens on the edge that ends the TIMEOUT-th busy cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              if_gnt_d, ls_gnt_d, if_valid_d, ls_valid_d, err_d;
    logic [ADDR_W-1:0] if_rdata_d, ls_rdata_d;
    logic              ls_wins;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ls_q, last_ls_d;

    assign ls_wins = ls_req && (!if_req || !last_ls_q);

    always_comb begin
        last_ls_d = last_ls_q;
        if (state_q == IDLE && (ls_req || if_req))
            last_ls_d = ls_wins;
    end

    always_ff @(posedge clk) begin
        if (reset) last_ls_q <= 1'b0;
        else       last_ls_q <= last_ls_d;
    end
`else
    assign ls_wins = ls_req;
`endif

    // The memory port only ever reflects the latched transaction, never live requester inputs.
    assign mem_en    = (state_q == BUSY_IF) || (state_q == BUSY_LS);
    assign mem_we    = (state_q == BUSY_LS) && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = (state_q == BUSY_LS) ? wdata_q : '0;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_gnt_d   = 1'b0;
        ls_gnt_d   = 1'b0;
        if_valid_d = 1'b0;
        ls_valid_d = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata;
        ls_rdata_d = ls_rdata;

        case (state_q)
            IDLE: begin
                if (ls_wins) begin
                    state_d  = BUSY_LS;
                    ls_gnt_d = 1'b1;
                    cnt_d    = '0;
                    addr_d   = ls_addr;
                    we_d     = ls_we;
                    wdata_d  = ls_wdata;
                end else if (if_req) begin
                    state_d  = BUSY_IF;
                    if_gnt_d = 1'b1;
                    cnt_d    = '0;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (state_q == BUSY_LS) begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = we_q ? '0 : mem_rdata;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (state_q == BUSY_LS) begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = '0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            if_gnt   <= 1'b0;
            ls_gnt   <= 1'b0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            err      <= 1'b0;
            if_rdata <= '0;
            ls_rdata <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            if_gnt   <= if_gnt_d;
            ls_gnt   <= ls_gnt_d;
            if_valid <= if_valid_d;
            ls_valid <= ls_valid_d;
            err      <= err_d;
            if_rdata <= if_rdata_d;
            ls_rdata <= ls_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (winner, busy length, abort, returned data).
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req, ls_req, ls_we, mem_ready;
    logic [ADDR_W-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic              if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we, err;
    logic [ADDR_W-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: last completed data per requester, last conflict winner.
    logic [31:0] m_if_rdata, m_ls_rdata;
    bit          m_last_ls;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_valid"}, if_valid, 0);
        check({tag, "_ls_valid"}, ls_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_gnt"}, {if_gnt, ls_gnt}, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_if_rdata"}, if_rdata, m_if_rdata);
        check({tag, "_ls_rdata"}, ls_rdata, m_ls_rdata);
    endtask

    // Entered and left in an IDLE cycle (#1 after the edge). delay = busy cycles before ready;
    // delay >= TIMEOUT means the memory never answers.
    task automatic run_txn(input bit rq_if, input bit rq_ls, input bit we,
                           input logic [31:0] a_if, input logic [31:0] a_ls,
                           input logic [31:0] wd, input logic [31:0] rd, input int delay);
        bit          win_ls;
        bit          abort;
        int          busy;
        logic [31:0] exp_addr;
        if_req   = rq_if;
        ls_req   = rq_ls;
        if_addr  = a_if;
        ls_addr  = a_ls;
        ls_we    = we;
        ls_wdata = wd;
`ifdef ARB_ROUND_ROBIN_EN
        win_ls    = rq_ls && (!rq_if || !m_last_ls);
        m_last_ls = win_ls;
`else
        win_ls = rq_ls;
`endif
        abort    = delay >= TIMEOUT;
        busy     = abort ? TIMEOUT : delay + 1;
        exp_addr = win_ls ? a_ls : a_if;
        check_quiet("idle_pre");
        tick();
        for (int k = 0; k < busy; k++) begin
            mem_ready = !abort && (k == delay);
            mem_rdata = (k == delay) ? rd : $urandom();
            check("busy_if_gnt", if_gnt, (k == 0) && !win_ls);
            check("busy_ls_gnt", ls_gnt, (k == 0) && win_ls);
            check("busy_mem_en", mem_en, 1);
            check("busy_mem_addr", mem_addr, exp_addr);
            check("busy_mem_we", mem_we, win_ls && we);
            if (win_ls && we) check("busy_mem_wdata", mem_wdata, wd);
            check("busy_valid", {if_valid, ls_valid, err}, 0);
            if (k == 0) begin
                // Requester sees its grant and withdraws; scramble inputs to prove latching.
                if (win_ls) ls_req = 1'b0;
                else        if_req = 1'b0;
                if_addr  = $urandom();
                ls_addr  = $urandom();
                ls_wdata = $urandom();
            end
            tick();
        end
        if (win_ls) m_ls_rdata = (abort || we) ? 32'h0 : rd;
        else        m_if_rdata = abort ? 32'h0 : rd;
        check("done_if_valid", if_valid, !win_ls);
        check("done_ls_valid", ls_valid, win_ls);
        check("done_err", err, abort);
        check("done_if_rdata", if_rdata, m_if_rdata);
        check("done_ls_rdata", ls_rdata, m_ls_rdata);
        check("done_mem_en", mem_en, 0);
        check("done_gnt", {if_gnt, ls_gnt}, 0);
        mem_ready = $urandom_range(0, 1);
        mem_rdata = $urandom();
        tick();
        check_quiet("idle_post");
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        if_addr   = '0;
        ls_addr   = '0;
        ls_wdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        m_if_rdata = '0;
        m_ls_rdata = '0;
        m_last_ls  = 1'b0;
        tick();
        check("rst_outputs", {if_gnt, ls_gnt, if_valid, ls_valid, mem_en, mem_we, err}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_rdata", if_rdata, 0);
        reset = 1'b0;

        // Immediate-ready fetch.
        run_txn(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'hC000_0010, 0);
        // Store held for three busy cycles.
        run_txn(0, 1, 1, 32'h0, 32'h40, 32'hDEAD_BEEF, 32'h1234_5678, 2);
        // Both requesters held across four transactions, then fetch alone.
        run_txn(1, 1, 0, 32'h100, 32'h200, 32'h0, 32'hA1, 0);
        run_txn(1, 1, 0, 32'h104, 32'h204, 32'h0, 32'hA2, 1);
        run_txn(1, 1, 1, 32'h108, 32'h208, 32'h55, 32'hA3, 0);
        run_txn(1, 1, 0, 32'h10C, 32'h20C, 32'h0, 32'hA4, 3);
        run_txn(1, 0, 0, 32'h110, 32'h0, 32'h0, 32'hA5, 0);
        // Memory never ready: abort after TIMEOUT busy cycles.
        run_txn(1, 0, 0, 32'h300, 32'h0, 32'h0, 32'hBAD, 1000);
        // Ready on the very last allowed cycle wins over the timeout.
        run_txn(0, 1, 0, 32'h0, 32'h400, 32'h0, 32'h7777_0001, TIMEOUT - 1);

        // Ready strobe in IDLE and a request withdrawn before it is sampled.
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        if_req    = 1'b1;
        #3;
        if_req = 1'b0;
        tick();
        check_quiet("idle_ready");
        tick();
        check_quiet("idle_ready2");
        mem_ready = 1'b0;

        // Reset during the second busy cycle of a load.
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h80;
        tick();
        check("rst_mid_gnt", ls_gnt, 1);
        ls_req = 1'b0;
        tick();
        check("rst_mid_busy", mem_en, 1);
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        m_if_rdata = '0;
        m_ls_rdata = '0;
        m_last_ls  = 1'b0;
        check("rst_mid_mem_addr", mem_addr, 0);
        check_quiet("rst_mid");
        tick();
        check_quiet("rst_mid_after");
        run_txn(0, 1, 0, 32'h0, 32'h84, 32'h0, 32'h0BAD_F00D, 1);

        // Randomized transactions.
        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom_range(0, TIMEOUT + 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
